// File: rtl/sram_mailbox_master.sv
// Fabric-side mailbox initiator on onchip_sram_s1: polls a command word, fetches
// solver parameters, runs the solver, writes result + ack. Optional watchdog: MAILBOX_TIMEOUT_EN.
module sram_mailbox_master #(
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned NUM_PARAMS     = 4,
  parameter int unsigned CMD_ADDR       = 0,
  parameter int unsigned PARAM_BASE     = 1,
  parameter int unsigned RESULT_ADDR    = 8,
  parameter int unsigned ACK_ADDR       = 9,
  parameter int unsigned POLL_INTERVAL  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1 << 24
) (
  input  logic                       clk,
  input  logic                       reset_n,
  output logic [7:0]                 sram_address,
  output logic                       sram_clken,
  output logic                       sram_chipselect,
  output logic                       sram_write,
  input  logic [31:0]                sram_readdata,
  output logic [31:0]                sram_writedata,
  output logic [3:0]                 sram_byteenable,
  output logic [32*NUM_PARAMS-1:0]   param_bus,
  output logic                       solver_start,
  input  logic                       solver_done,
  input  logic [31:0]                solver_result,
  output logic                       busy
);

  typedef enum logic [3:0] {
    IDLE, POLL, POLL_WAIT, FETCH, FETCH_WAIT, START, RUN, WR_RES, WR_ACK
  } state_e;

  localparam int PC_W  = $clog2(POLL_INTERVAL + 1);
  localparam int IDX_W = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1;

  state_e                        state_q, state_d;
  logic [PC_W-1:0]               poll_cnt_q;
  logic [1:0]                    lat_q;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [31:0]                   cur_seq_q, last_seq_q, res_d;
  logic [NUM_PARAMS-1:0][31:0]   params_q;
  logic                          cap, cmd_ok, run_end;

  logic [7:0]  addr_d;
  logic [31:0] wdata_d;
  logic        cs_d, we_d, start_d, busy_d;

  // Capture point of a read: READ_LATENCY cycles after its issue cycle.
  assign cap    = (lat_q == 2'(READ_LATENCY - 1));
  assign cmd_ok = (sram_readdata != '0) && (sram_readdata != last_seq_q);

`ifdef MAILBOX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_q;
  logic            timeout;

  assign timeout = (state_q == RUN) && !solver_done && (to_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign run_end = solver_done || timeout;
  assign res_d   = solver_done ? solver_result : 32'hFFFF_FFFF;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              to_q <= '0;
    else if (state_q == RUN)   to_q <= to_q + TO_W'(1);
    else                       to_q <= '0;
  end
`else
  assign run_end = solver_done;
  assign res_d   = solver_result;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE:       if (poll_cnt_q == PC_W'(POLL_INTERVAL - 1)) state_d = POLL;
      POLL:       state_d = POLL_WAIT;
      POLL_WAIT: begin
        idx_d = '0;
        if (cap) state_d = cmd_ok ? FETCH : IDLE;
      end
      FETCH:      state_d = FETCH_WAIT;
      FETCH_WAIT: if (cap) begin
        if (idx_q == IDX_W'(NUM_PARAMS - 1)) state_d = START;
        else begin
          state_d = FETCH;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      START:      state_d = RUN;
      RUN:        if (run_end) state_d = WR_RES;
      WR_RES:     state_d = WR_ACK;
      WR_ACK:     state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Bus outputs are registered, so they are derived from the next state.
  always_comb begin
    cs_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    unique case (state_d)
      POLL:   begin cs_d = 1'b1; addr_d = 8'(CMD_ADDR); end
      FETCH:  begin cs_d = 1'b1; addr_d = 8'(PARAM_BASE) + 8'(idx_d); end
      WR_RES: begin cs_d = 1'b1; we_d = 1'b1; addr_d = 8'(RESULT_ADDR); wdata_d = res_d; end
      WR_ACK: begin cs_d = 1'b1; we_d = 1'b1; addr_d = 8'(ACK_ADDR); wdata_d = cur_seq_q; end
      default: ;
    endcase
    start_d = (state_d == START);
    busy_d  = (state_d == FETCH) || (state_d == FETCH_WAIT) || (state_d == START) ||
              (state_d == RUN) || (state_d == WR_RES) || (state_d == WR_ACK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_address    <= '0;
      sram_clken      <= 1'b0;
      sram_chipselect <= 1'b0;
      sram_write      <= 1'b0;
      sram_writedata  <= '0;
      sram_byteenable <= '0;
      solver_start    <= 1'b0;
      busy            <= 1'b0;
    end else begin
      sram_address    <= addr_d;
      sram_clken      <= 1'b1;
      sram_chipselect <= cs_d;
      sram_write      <= we_d;
      sram_writedata  <= wdata_d;
      sram_byteenable <= cs_d ? 4'hF : 4'h0;
      solver_start    <= start_d;
      busy            <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt_q <= '0;
      lat_q      <= '0;
      idx_q      <= '0;
      cur_seq_q  <= '0;
      last_seq_q <= '0;
      params_q   <= '0;
    end else begin
      poll_cnt_q <= (state_q == IDLE && state_d == IDLE) ? poll_cnt_q + PC_W'(1) : '0;
      lat_q      <= ((state_q == POLL_WAIT || state_q == FETCH_WAIT) && !cap) ? lat_q + 2'd1 : 2'd0;
      idx_q      <= idx_d;
      if (state_q == POLL_WAIT && cap && cmd_ok) cur_seq_q <= sram_readdata;
      // Params only move on an accepted command's fetch, never on a rejected poll.
      if (state_q == FETCH_WAIT && cap) params_q[idx_q] <= sram_readdata;
      if (state_q == WR_ACK) last_seq_q <= cur_seq_q;
    end
  end

  assign param_bus = params_q;

endmodule
